dwconv_sequencer: RTL

Sequencer for the depthwise convolution datapath. It walks every output position of every channel of a feature map held in an external activation memory. For each position it fetches the K×K activation window and matching per-channel weights, multiply-accumulates them, and presents one requantized output pixel per handshake. The block sits between the activation/weight SRAMs and the downstream pointwise stage; it covers channel multiplier 1, stride 1 and no padding.

---
 rtl/dwconv_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dwconv_sequencer.sv
// Depthwise convolution sequencer: walks every output pixel of every channel,
// issues K*K activation/weight reads per window, accumulates and requantizes.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one tap read per cycle
//   DRAIN | last product lands in acc
//   EMIT  | pixel presented until out_ready
module dwconv_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int CHANNELS    = 3,
  parameter int ACC_WIDTH   = 24,
  parameter int OUT_SHIFT   = 0,
  localparam int OH  = IMG_HEIGHT - KERNEL_SIZE + 1,
  localparam int OW  = IMG_WIDTH - KERNEL_SIZE + 1,
  localparam int AAW = (CHANNELS*IMG_HEIGHT*IMG_WIDTH > 1) ? $clog2(CHANNELS*IMG_HEIGHT*IMG_WIDTH) : 1,
  localparam int WAW = (CHANNELS*KERNEL_SIZE*KERNEL_SIZE > 1) ? $clog2(CHANNELS*KERNEL_SIZE*KERNEL_SIZE) : 1,
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int RW  = (OH > 1) ? $clog2(OH) : 1,
  localparam int XW  = (OW > 1) ? $clog2(OW) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [AAW-1:0]               act_addr,
  input  logic signed [DATA_WIDTH-1:0] act_data,
  output logic [WAW-1:0]               wgt_addr,
  input  logic signed [DATA_WIDTH-1:0] wgt_data,
  output logic                         mem_rd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [CW-1:0]                out_chan,
  output logic [RW-1:0]                out_row,
  output logic [XW-1:0]                out_col
);

  localparam int KW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-(2**(DATA_WIDTH-1)));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_EMIT} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [XW-1:0] x;
  logic [KW-1:0] ky, kx;
  logic rd_d, first_d;
  logic signed [ACC_WIDTH-1:0] acc, shifted, prod_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic tap_last, pix_last, handshake;

  assign tap_last  = (ky == KW'(KERNEL_SIZE-1)) && (kx == KW'(KERNEL_SIZE-1));
  assign pix_last  = (c == CW'(CHANNELS-1)) && (r == RW'(OH-1)) && (x == XW'(OW-1));
  assign handshake = (state == S_EMIT) && out_ready;

  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        mem_rd = 1'b1;
        if (tap_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_EMIT;
      S_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = pix_last ? S_IDLE : S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      c <= '0; r <= '0; x <= '0; ky <= '0; kx <= '0;
      rd_d <= 1'b0; first_d <= 1'b0;
      acc <= '0;
      done <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_d    <= mem_rd;
      first_d <= mem_rd && (ky == '0) && (kx == '0);
      done    <= handshake && pix_last;
      if (state == S_IDLE && start) begin
        c <= '0; r <= '0; x <= '0; ky <= '0; kx <= '0;
      end
      if (state == S_RUN) begin
        if (kx == KW'(KERNEL_SIZE-1)) begin
          kx <= '0;
          ky <= (ky == KW'(KERNEL_SIZE-1)) ? '0 : ky + 1'b1;
        end else begin
          kx <= kx + 1'b1;
        end
      end
      if (handshake) begin
        if (x == XW'(OW-1)) begin
          x <= '0;
          if (r == RW'(OH-1)) begin
            r <= '0;
            c <= (c == CW'(CHANNELS-1)) ? '0 : c + 1'b1;
          end else begin
            r <= r + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
      // read data lags its address by one cycle, so accumulate on the delayed strobe
      if (rd_d) acc <= first_d ? prod_ext : acc + prod_ext;
    end
  end

  assign prod     = act_data * wgt_data;
  assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign shifted  = acc >>> OUT_SHIFT;

  always_comb begin
    if (shifted > SAT_MAX)      out_data = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) out_data = SAT_MIN[DATA_WIDTH-1:0];
    else                        out_data = shifted[DATA_WIDTH-1:0];
  end

  assign act_addr = AAW'(c) * AAW'(IMG_HEIGHT*IMG_WIDTH)
                  + (AAW'(r) + AAW'(ky)) * AAW'(IMG_WIDTH)
                  + AAW'(x) + AAW'(kx);
  assign wgt_addr = WAW'(c) * WAW'(KERNEL_SIZE*KERNEL_SIZE)
                  + WAW'(ky) * WAW'(KERNEL_SIZE) + WAW'(kx);
  assign busy     = (state != S_IDLE);
  assign out_chan = c;
  assign out_row  = r;
  assign out_col  = x;

endmodule
